// File: rtl/load_arbiter.sv
// Round-robin arbiter sharing one serial load/run link among N_REQ loader masters,
// with a forced-idle gap between sessions and a run-mode watchdog abort.
`timescale 1ns/1ps
module load_arbiter #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   mosi_in,
  input  logic [2*N_REQ-1:0] mode_in,
  input  logic               done_in,
  output logic [N_REQ-1:0]   done_out,
  output logic [N_REQ-1:0]   grant,
  output logic               mosi_out,
  output logic [1:0]         mode_out,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]    GLAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     rr_ptr;
  logic [N_REQ-1:0]  abort_mask;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  mask_next;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  int unsigned       cand;
  logic              g_mosi;
  logic [1:0]        g_mode;
  logic              run_cycle;
  logic              abort;

  assign eligible = req & ~abort_mask;

  // First eligible master strictly after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && eligible[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    g_mosi = mosi_in[gidx];
    g_mode = mode_in[{gidx, 1'b0} +: 2];
  end

  assign run_cycle   = (state == GRANT) && (g_mode == 2'b11) && !done_in;
  assign abort       = run_cycle && (tcnt == TLAST);
  assign timeout_err = abort;
  assign busy        = (state != IDLE);

  always_comb begin
    mosi_out = 1'b0;
    mode_out = 2'b00;
    done_out = '0;
    if (state == GRANT) begin
      mosi_out       = g_mosi;
      mode_out       = g_mode;
      done_out[gidx] = done_in;
    end
  end

  // An abort on the same edge as a req drop still leaves the master masked.
  always_comb begin
    mask_next = abort_mask & req;
    if (abort) mask_next[gidx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= IW'(N_REQ - 1);
      abort_mask <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      abort_mask <= mask_next;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (win_found) begin
            grant  <= ONE << win_idx;
            gidx   <= win_idx;
            rr_ptr <= win_idx;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (abort || !req[gidx]) begin
            grant <= '0;
            tcnt  <= '0;
            gcnt  <= '0;
            state <= GAP;
          end else if (run_cycle) begin
            if (tcnt != '1) tcnt <= tcnt + 1'b1;
          end else begin
            tcnt <= '0;
          end
        end
        GAP: begin
          if (GAP_CYCLES == 0 || gcnt == GLAST) begin
            gcnt  <= '0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_arbiter.sv
// Directed self-checking bench for load_arbiter (N_REQ=2, GAP_CYCLES=2, TIMEOUT=8).
`timescale 1ns/1ps
module tb_load_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] mosi_in = '0;
  logic [3:0] mode_in = '0;
  logic       done_in = 1'b0;
  logic [1:0] done_out;
  logic [1:0] grant;
  logic       mosi_out;
  logic [1:0] mode_out;
  logic       busy;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  load_arbiter #(.N_REQ(2), .GAP_CYCLES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mosi_in(mosi_in), .mode_in(mode_in),
    .done_in(done_in), .done_out(done_out), .grant(grant), .mosi_out(mosi_out),
    .mode_out(mode_out), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; mode_in = '0; mosi_in = '0; done_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({grant, mode_out, mosi_out, done_out, busy, timeout_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {grant, mode_out, mosi_out, done_out, busy, timeout_err}, 9'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    step();
    req = 2'b01; mode_in = 4'b11_01; mosi_in = 2'b01;
    #1; total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL single_pre_grant got=%b exp=00", grant); end
    step();
    total++;
    if ({grant, busy, mode_out, mosi_out} !== 6'b01_1_01_1) begin
      bad++; $display("FAIL single_grant got=%b exp=011011", {grant, busy, mode_out, mosi_out});
    end
    mode_in = 4'b11_10; mosi_in = 2'b10;
    #1; total++;
    if ({mode_out, mosi_out} !== 3'b10_0) begin
      bad++; $display("FAIL single_track got=%b exp=100", {mode_out, mosi_out});
    end
    step();
    req = 2'b00;
    step();
    total++;
    if ({grant, mode_out, busy} !== 5'b00_00_1) begin
      bad++; $display("FAIL single_gap1 got=%b exp=00001", {grant, mode_out, busy});
    end
    step();
    total++;
    if ({grant, mode_out, busy} !== 5'b00_00_1) begin
      bad++; $display("FAIL single_gap2 got=%b exp=00001", {grant, mode_out, busy});
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy got=%b exp=0", busy); end
    mode_in = '0; mosi_in = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int zeros;
    do_reset();
    req = 2'b11; mode_in = 4'b01_01;
    for (int s = 0; s < 4; s++) begin
      zeros = 0;
      while (grant == 2'b00 && zeros < 10) begin
        step();
        zeros++;
      end
      total++;
      if (grant !== exp_seq[s]) begin
        bad++; $display("FAIL rr_grant%0d got=%b exp=%b", s, grant, exp_seq[s]);
      end
      if (s > 0) begin
        total++;
        if (zeros != 3) begin bad++; $display("FAIL rr_gap%0d got=%0d exp=3", s, zeros); end
      end
      repeat (20) step();
      req = req & ~exp_seq[s];
      step();
      req = 2'b11;
    end
    req = 2'b00;
    repeat (4) step();
    mode_in = '0;
  endtask

  task automatic test_done_routing();
    req = 2'b10;
    step();
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL done_grant got=%b exp=10", grant); end
    done_in = 1'b1;
    #1; total++;
    if (done_out !== 2'b10) begin bad++; $display("FAIL done_route got=%b exp=10", done_out); end
    done_in = 1'b0;
    #1; total++;
    if (done_out !== 2'b00) begin bad++; $display("FAIL done_low got=%b exp=00", done_out); end
    req = 2'b00;
    step();
    done_in = 1'b1;
    #1; total++;
    if ({grant, done_out} !== 4'b0000) begin
      bad++; $display("FAIL done_gap got=%b exp=0000", {grant, done_out});
    end
    done_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b01; mode_in = 4'b00_11;
    step();
    for (int k = 1; k <= 8; k++) begin
      total++;
      if ({grant, timeout_err} !== {2'b01, (k == 8)}) begin
        bad++; $display("FAIL tmo_cycle%0d got=%b exp=%b", k, {grant, timeout_err}, {2'b01, (k == 8)});
      end
      if (k < 8) step();
    end
    step();
    req = 2'b11;
    total++;
    if ({grant, timeout_err, busy} !== 4'b00_0_1) begin
      bad++; $display("FAIL tmo_abort got=%b exp=0001", {grant, timeout_err, busy});
    end
    repeat (3) step();
    total++;
    if (grant !== 2'b10) begin bad++; $display("FAIL tmo_other got=%b exp=10", grant); end
    req = 2'b01;
    repeat (4) step();
    total++;
    if ({grant, busy} !== 3'b00_0) begin
      bad++; $display("FAIL tmo_masked got=%b exp=000", {grant, busy});
    end
    req = 2'b00; mode_in = 4'b00_01;
    step();
    req = 2'b01;
    step();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL tmo_regrant got=%b exp=01", grant); end
    req = 2'b00;
    repeat (3) step();
  endtask

  task automatic test_timeout_avoided();
    req = 2'b01; mode_in = 4'b00_11;
    step();
    for (int k = 1; k <= 14; k++) begin
      done_in = (k == 7);
      #1; total++;
      if ({grant, timeout_err} !== 3'b01_0) begin
        bad++; $display("FAIL avoid_cycle%0d got=%b exp=010", k, {grant, timeout_err});
      end
      step();
    end
    done_in = 1'b0;
    req = 2'b00; mode_in = '0;
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    req = 2'b11; mode_in = 4'b01_01;
    step();
    total++;
    if ({grant, mode_out} !== 4'b10_01) begin
      bad++; $display("FAIL ares_pre got=%b exp=1001", {grant, mode_out});
    end
    #2 rst = 1'b1;
    #1; total++;
    if ({grant, mode_out, busy} !== 5'b0) begin
      bad++; $display("FAIL ares_async got=%b exp=00000", {grant, mode_out, busy});
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL ares_restart got=%b exp=01", grant); end
    req = 2'b00;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_done_routing();
    test_timeout();
    test_timeout_avoided();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
